// File: rtl/imem_boot_loader.sv
// Boot sequencer: takes a length-prefixed little-endian byte stream, writes 32-bit words
// into instruction memory through the program-load port, then releases the core until it halts.
module imem_boot_loader #(
  parameter int          IMEM_BYTES = 4096,
  parameter logic [63:0] BASE_ADDR  = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_load_en,
  output logic [63:0] prog_addr,
  output logic [31:0] prog_data,
  output logic        cpu_reset,
  input  logic        cpu_halted,
  output logic        busy,
  output logic        running,
  output logic        done,
  output logic        error,
  output logic [15:0] words_loaded,
  output logic [2:0]  dbg_state
);

  // rx handshake: a byte moves when rx_valid & rx_ready on a rising edge.
  // rx_ready depends only on state, never on rx_valid.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR0  = 3'd1,
    S_HDR1  = 3'd2,
    S_DATA  = 3'd3,
    S_WRITE = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [16:0] MAX_WORDS = 17'(IMEM_BYTES / 4);

  state_t      r_state;
  state_t      w_next;
  logic        w_accept;
  logic [15:0] w_n_full;
  logic [15:0] r_n;
  logic [1:0]  r_idx;
  logic [31:0] r_word;
  logic [15:0] r_words;
  logic [63:0] r_addr;
  logic        r_load_en;
  logic        r_cpu_reset;
  logic        r_busy;
  logic        r_running;
  logic        r_done;
  logic        r_error;

  assign rx_ready     = (r_state == S_HDR0) || (r_state == S_HDR1) || (r_state == S_DATA);
  assign w_accept     = rx_valid & rx_ready;
  assign w_n_full     = {rx_data, r_n[7:0]};
  assign prog_load_en = r_load_en;
  assign prog_addr    = r_addr;
  assign prog_data    = r_word;
  assign cpu_reset    = r_cpu_reset;
  assign busy         = r_busy;
  assign running      = r_running;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words;
  assign dbg_state    = r_state;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_HDR0;
      S_HDR0:  if (w_accept) w_next = S_HDR1;
      S_HDR1:  if (w_accept) begin
        if ((w_n_full == 16'd0) || ({1'b0, w_n_full} > MAX_WORDS)) w_next = S_ERR;
        else w_next = S_DATA;
      end
      S_DATA:  if (w_accept && (r_idx == 2'd3)) w_next = S_WRITE;
      S_WRITE: w_next = ((r_words + 16'd1) == r_n) ? S_RUN : S_DATA;
      S_RUN:   if (cpu_halted) w_next = S_DONE;
      S_DONE:  if (start) w_next = S_HDR0;
      S_ERR:   if (start) w_next = S_HDR0;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_n         <= 16'd0;
      r_idx       <= 2'd0;
      r_word      <= 32'd0;
      r_words     <= 16'd0;
      r_addr      <= BASE_ADDR;
      r_load_en   <= 1'b0;
      r_cpu_reset <= 1'b1;
      r_busy      <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR))) begin
        r_words <= 16'd0;
        r_addr  <= BASE_ADDR;
      end
      if ((r_state == S_HDR0) && w_accept) r_n[7:0] <= rx_data;
      if ((r_state == S_HDR1) && w_accept) begin
        r_n[15:8] <= rx_data;
        r_idx     <= 2'd0;
      end
      // Bytes arrive LSB first, so shifting in from the top leaves byte 0 in [7:0].
      if ((r_state == S_DATA) && w_accept) begin
        r_word <= {rx_data, r_word[31:8]};
        r_idx  <= r_idx + 2'd1;
      end
      if (r_state == S_WRITE) begin
        r_words <= r_words + 16'd1;
        r_addr  <= r_addr + 64'd4;
      end
      // Status outputs are registered from the next state so they line up with it.
      r_load_en   <= (w_next == S_WRITE);
      r_cpu_reset <= !((w_next == S_RUN) || (w_next == S_DONE));
      r_busy      <= (w_next == S_HDR0) || (w_next == S_HDR1) ||
                     (w_next == S_DATA) || (w_next == S_WRITE);
      r_running   <= (w_next == S_RUN);
      r_done      <= (w_next == S_DONE);
      r_error     <= (w_next == S_ERR);
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed bench for imem_boot_loader: scripted streams, expected-write queue, immediate assertions.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_load_en;
  logic [63:0] prog_addr;
  logic [31:0] prog_data;
  logic        cpu_reset;
  logic        cpu_halted;
  logic        busy;
  logic        running;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [2:0]  dbg_state;

  int checks   = 0;
  int failures = 0;

  logic [95:0] exp_q[$];
  logic [31:0] img[$];
  logic [63:0] last_addr = 64'hFFFF_FFFF_FFFF_FFFF;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_HDR0 = 3'd1, ST_RUN = 3'd5,
                         ST_DONE = 3'd6, ST_ERR = 3'd7;

  imem_boot_loader #(.IMEM_BYTES(4096), .BASE_ADDR(64'h0)) dut (
    .clk(clk), .reset(reset), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .prog_load_en(prog_load_en), .prog_addr(prog_addr),
    .prog_data(prog_data), .cpu_reset(cpu_reset), .cpu_halted(cpu_halted), .busy(busy),
    .running(running), .done(done), .error(error), .words_loaded(words_loaded),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Every write strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (prog_load_en === 1'b1) begin
      chk("ready_low_in_write", {63'd0, rx_ready}, 64'd0);
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {63'd0, prog_load_en}, 64'd0);
      end else begin
        logic [95:0] e;
        e = exp_q.pop_front();
        chk("write_addr", prog_addr, e[95:32]);
        chk("write_data", {32'd0, prog_data}, {32'd0, e[31:0]});
        last_addr = prog_addr;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    for (int g = 0; g < gap; g++) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int t = 0; t < 50 && !rx_ready; t++) @(negedge clk);
    if (!rx_ready) chk("rx_ready_timeout", {63'd0, rx_ready}, 64'd1);
    else @(posedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Streams img as a full image and checks the hand-off from the last WRITE into RUN.
  task automatic run_load(input int gap, input string tag);
    logic [15:0] n;
    n = 16'(img.size());
    for (int i = 0; i < img.size(); i++) exp_q.push_back({64'(i) * 64'd4, img[i]});
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int i = 0; i < img.size(); i++)
      for (int k = 0; k < 4; k++) send_byte(img[i][8*k +: 8], gap);
    @(negedge clk);
    rx_valid = 1'b0;
    chk({tag, "_last_strobe"}, {63'd0, prog_load_en}, 64'd1);
    chk({tag, "_cpu_held_in_write"}, {63'd0, cpu_reset}, 64'd1);
    @(negedge clk);
    chk({tag, "_cpu_released"}, {63'd0, cpu_reset}, 64'd0);
    chk({tag, "_running"}, {63'd0, running}, 64'd1);
    chk({tag, "_busy_clear"}, {63'd0, busy}, 64'd0);
    chk({tag, "_words_loaded"}, {48'd0, words_loaded}, {48'd0, n});
    chk({tag, "_state_run"}, {61'd0, dbg_state}, {61'd0, ST_RUN});
  endtask

  task automatic halt_core(input string tag);
    @(negedge clk);
    cpu_halted = 1'b1;
    @(negedge clk);
    cpu_halted = 1'b0;
    chk({tag, "_done"}, {63'd0, done}, 64'd1);
    chk({tag, "_running_clear"}, {63'd0, running}, 64'd0);
    chk({tag, "_cpu_reset_stays_low"}, {63'd0, cpu_reset}, 64'd0);
    chk({tag, "_state_done"}, {61'd0, dbg_state}, {61'd0, ST_DONE});
  endtask

  task automatic set_prog_image();
    img.delete();
    img.push_back(32'h00A00513);
    img.push_back(32'h00B00593);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; cpu_halted = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("rst_prog_load_en", {63'd0, prog_load_en}, 64'd0);
    chk("rst_prog_addr", prog_addr, 64'h0);
    chk("rst_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_flags", {61'd0, running, done, error}, 64'd0);
    chk("rst_words", {48'd0, words_loaded}, 64'd0);
    chk("rst_state", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    reset = 1'b0;

    // Back-to-back stream of two words.
    pulse_start();
    chk("t1_state_hdr0", {61'd0, dbg_state}, {61'd0, ST_HDR0});
    chk("t1_busy", {63'd0, busy}, 64'd1);
    chk("t1_rx_ready", {63'd0, rx_ready}, 64'd1);
    set_prog_image();
    run_load(0, "t1");
    // start is ignored while the core runs.
    pulse_start();
    chk("t5_start_ignored_state", {61'd0, dbg_state}, {61'd0, ST_RUN});
    chk("t5_start_ignored_running", {63'd0, running}, 64'd1);
    halt_core("t5");
    repeat (2) @(negedge clk);
    chk("t5_done_holds", {63'd0, done}, 64'd1);

    // Restart from DONE, then the same image with 3-cycle gaps.
    pulse_start();
    chk("t2_cpu_reset_back", {63'd0, cpu_reset}, 64'd1);
    chk("t2_state_hdr0", {61'd0, dbg_state}, {61'd0, ST_HDR0});
    chk("t2_done_cleared", {63'd0, done}, 64'd0);
    chk("t2_words_cleared", {48'd0, words_loaded}, 64'd0);
    run_load(3, "t2");
    halt_core("t2");

    // Zero-length header is rejected.
    pulse_start();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t3_error", {63'd0, error}, 64'd1);
    chk("t3_rx_ready", {63'd0, rx_ready}, 64'd0);
    chk("t3_cpu_reset", {63'd0, cpu_reset}, 64'd1);
    chk("t3_state_err", {61'd0, dbg_state}, {61'd0, ST_ERR});
    pulse_start();
    chk("t3_error_cleared", {63'd0, error}, 64'd0);
    img.delete();
    img.push_back(32'h12345678);
    run_load(1, "t3");
    halt_core("t3");

    // N = 1025 is one word too many.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h04, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    chk("t4_over_error", {63'd0, error}, 64'd1);
    chk("t4_over_state", {61'd0, dbg_state}, {61'd0, ST_ERR});
    chk("t4_over_words", {48'd0, words_loaded}, 64'd0);

    // N = 1024 fills memory exactly.
    pulse_start();
    img.delete();
    for (int i = 0; i < 1024; i++) img.push_back(32'(i) * 32'h0001_0003 + 32'h0000_0013);
    run_load(0, "t4");
    chk("t4_last_addr", last_addr, 64'h0000_0000_0000_0FFC);
    halt_core("t4");

    // Reset in the middle of word 0 aborts immediately.
    pulse_start();
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    @(negedge clk);
    rx_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("t6_cpu_reset_async", {63'd0, cpu_reset}, 64'd1);
    chk("t6_load_en_async", {63'd0, prog_load_en}, 64'd0);
    chk("t6_busy_async", {63'd0, busy}, 64'd0);
    chk("t6_state_async", {61'd0, dbg_state}, {61'd0, ST_IDLE});
    chk("t6_addr_async", prog_addr, 64'h0);
    @(negedge clk);
    reset = 1'b0;
    pulse_start();
    set_prog_image();
    run_load(0, "t6");
    halt_core("t6");

    repeat (2) @(negedge clk);
    chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    chk("global_timeout", {61'd0, dbg_state}, 64'hFFFF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
Boot sequencer for the single-cycle RV64I core. It receives a byte stream through a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes those words into instruction memory through the core's program-load port, holding the core in reset throughout. Once the image is loaded it releases the core and reports completion when the core halts.

Parameters:
IMEM_BYTES, 4096, instruction memory size in bytes; max word count = IMEM_BYTES/4
BASE_ADDR, 64'h0, byte address of the first loaded word

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse to begin a load
rx_data  input  8  incoming stream byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts byte this cycle
prog_load_en  output  1  instruction memory write strobe
prog_addr  output  64  instruction memory write byte address
prog_data  output  32  instruction word to write
cpu_reset  output  1  held-in-reset control to core (1 = held)
cpu_halted  input  1  core halted flag
busy  output  1  load in progress (HDR0..WRITE)
running  output  1  core released and not yet halted
done  output  1  core halted after a successful load
error  output  1  header rejected
words_loaded  output  16  count of words written this load

Behaviour:
- Async reset: state = IDLE; cpu_reset = 1; all other outputs 0; prog_addr = BASE_ADDR; internal word count N = 0; byte index = 0.
- Byte accept = rx_valid & rx_ready. rx_ready = 1 only in HDR0, HDR1 and DATA. rx_ready is combinational from state and does not depend on rx_valid.
- All outputs except rx_ready are registered.
- Stream format: N[7:0], N[15:8], then N*4 data bytes. Each word is sent LSB first, so byte k of a word goes to prog_data[8k+7:8k].
- States:
  - IDLE: cpu_reset = 1. start moves to HDR0 and clears words_loaded, error and done.
  - HDR0: on accept, latch N[7:0] and move to HDR1.
  - HDR1: on accept, latch N[15:8]. If N == 0 or N > IMEM_BYTES/4, move to ERR. Otherwise move to DATA with byte index = 0.
  - DATA: on each accept, shift the byte into the assembly register and increment the byte index (2 bits, wraps). The 4th accepted byte moves to WRITE.
  - WRITE: lasts exactly 1 cycle. prog_load_en = 1 with prog_addr = BASE_ADDR + 4*words_loaded and prog_data = the assembled word. words_loaded increments at the end of the cycle. If the new words_loaded == N, move to RUN; otherwise return to DATA.
  - RUN: cpu_reset = 0 and running = 1, starting in the first cycle after WRITE. cpu_halted sampled high moves to DONE.
  - DONE: done = 1, running = 0, cpu_reset stays 0 so core state remains observable. start moves to HDR0 with cpu_reset = 1 from the next cycle.
  - ERR: error = 1, cpu_reset = 1, rx_ready = 0. start moves to HDR0.
- Gaps: rx_valid may drop at any time; state and byte index hold.
- start is ignored in HDR0, HDR1, DATA, WRITE and RUN.
- cpu_halted is ignored outside RUN.
- prog_load_en is never asserted outside WRITE, and at most once per word.
- Address arithmetic is 64-bit unsigned. words_loaded never exceeds N.
- The maximum of 1024 words gives a last address of BASE_ADDR + 0xFFC with no wrap.
- Reset asserted mid-load aborts the load immediately: prog_load_en = 0 and cpu_reset = 1 asynchronously. Partially written memory is left as is.
- Throughput: 5 cycles per word minimum (4 accepted bytes plus 1 WRITE cycle).

Test Plan:
- Reset, then start; stream 02 00 13 05 A0 00 93 05 B0 00 with rx_valid held high -> two writes: prog_addr = 0 with prog_data = 0x00A00513, then prog_addr = 4 with prog_data = 0x00B00593. rx_ready = 0 during each WRITE cycle. cpu_reset falls the cycle after the 2nd write. words_loaded = 2.
- Same stream with rx_valid low for 3 cycles between every byte -> identical writes and values. No prog_load_en during gaps.
- Header 00 00 -> error = 1, rx_ready = 0, cpu_reset = 1, no prog_load_en. A following start then a valid header -> error clears and the load proceeds.
- Header 01 04 (N = 1025) -> ERR; no writes. Header 00 04 (N = 1024) with full data -> last write at prog_addr = 0xFFC, then RUN.
- During RUN, pulse start (ignored), then raise cpu_halted -> done = 1, running = 0, cpu_reset stays 0. A later start -> cpu_reset = 1, state HDR0.
- Assert reset after 2 data bytes of word 0 -> all outputs return to reset values in the same cycle. A new start plus full stream loads correctly from prog_addr = 0.
